// File: rtl/mem_block_arbiter.sv
// Arbitrates N block-read requesters onto one memory read port, one transaction at a time.
// Optional statistics counters are enabled by defining MEM_BLOCK_ARB_STATS_EN.
package sys;
  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
  } mem_read_block_req_t;

  typedef struct packed {
    logic        done;
    logic [63:0] data;
  } mem_read_block_rsp_t;

  localparam mem_read_block_req_t mem_read_block_req_rst = '{valid: 1'b0, addr: 32'h0};
  localparam mem_read_block_rsp_t mem_read_block_rsp_rst = '{done: 1'b0, data: 64'h0};
endpackage

module mem_block_arbiter #(
  parameter int req_cnt    = 2,
  parameter bit fixed_prio = 1'b0,
  localparam int gid_w     = (req_cnt > 1) ? $clog2(req_cnt) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  sys::mem_read_block_req_t req_in  [req_cnt],
  output sys::mem_read_block_rsp_t rsp_out [req_cnt],
  output sys::mem_read_block_req_t mem_req,
  input  sys::mem_read_block_rsp_t mem_rsp,
  output logic                     busy,
  output logic [gid_w-1:0]         grant_id,
  output logic [1:0]               state_dbg
`ifdef MEM_BLOCK_ARB_STATS_EN
  ,
  output logic [31:0]              grant_cnt [req_cnt],
  output logic [31:0]              drop_cnt,
  output logic [31:0]              wait_cyc  [req_cnt]
`endif
);

  // Handshake: a requester raises valid with a stable addr and holds both until it sees
  // done on its rsp_out; done is a one-cycle pulse. Memory sees valid held until mem_rsp.done.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    RETIRE = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [gid_w-1:0]         grant_q, grant_d;
  logic [gid_w-1:0]         rr_q, rr_d;
  sys::mem_read_block_req_t mem_req_q, mem_req_d;
  logic                     win_vld;
  logic [gid_w-1:0]         win_id;
  logic                     drop;

  // Descending scan so the last hit is the highest-priority candidate.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    if (fixed_prio) begin
      for (int i = req_cnt - 1; i >= 0; i--) begin
        if (req_in[i].valid) begin
          win_vld = 1'b1;
          win_id  = gid_w'(i);
        end
      end
    end else begin
      for (int k = req_cnt - 1; k >= 0; k--) begin
        int idx;
        idx = int'(rr_q) + k;
        if (idx >= req_cnt) idx = idx - req_cnt;
        if (req_in[idx].valid) begin
          win_vld = 1'b1;
          win_id  = gid_w'(idx);
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    mem_req_d = mem_req_q;
    drop      = 1'b0;
    for (int i = 0; i < req_cnt; i++) rsp_out[i] = sys::mem_read_block_rsp_rst;
    case (state_q)
      IDLE: begin
        if (en && win_vld) begin
          grant_d         = win_id;
          mem_req_d.valid = 1'b1;
          mem_req_d.addr  = req_in[win_id].addr;
          state_d         = BUSY;
        end
      end
      BUSY: begin
        if (mem_rsp.done) begin
          mem_req_d = sys::mem_read_block_req_rst;
          state_d   = RETIRE;
          rr_d      = (grant_q == gid_w'(req_cnt - 1)) ? '0 : grant_q + 1'b1;
          // A requester that withdrew no longer owns the result; swallow it.
          if (req_in[grant_q].valid) rsp_out[grant_q] = mem_rsp;
          else                       drop = 1'b1;
        end
      end
      RETIRE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rr_q      <= '0;
      mem_req_q <= sys::mem_read_block_req_rst;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      mem_req_q <= mem_req_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign busy      = (state_q != IDLE);
  assign grant_id  = grant_q;
  assign state_dbg = state_q;

`ifdef MEM_BLOCK_ARB_STATS_EN
  logic [31:0] grant_cnt_q [req_cnt];
  logic [31:0] grant_cnt_d [req_cnt];
  logic [31:0] wait_cyc_q  [req_cnt];
  logic [31:0] wait_cyc_d  [req_cnt];
  logic [31:0] drop_cnt_q, drop_cnt_d;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_comb begin
    drop_cnt_d = drop ? sat_inc(drop_cnt_q) : drop_cnt_q;
    for (int i = 0; i < req_cnt; i++) begin
      logic granted_now;
      logic owned;
      granted_now    = (state_q == IDLE) && en && win_vld && (win_id == gid_w'(i));
      owned          = (state_q == BUSY) && (grant_q == gid_w'(i));
      grant_cnt_d[i] = granted_now ? sat_inc(grant_cnt_q[i]) : grant_cnt_q[i];
      wait_cyc_d[i]  = (req_in[i].valid && !granted_now && !owned) ?
                       sat_inc(wait_cyc_q[i]) : wait_cyc_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt_q <= '0;
      for (int i = 0; i < req_cnt; i++) begin
        grant_cnt_q[i] <= '0;
        wait_cyc_q[i]  <= '0;
      end
    end else begin
      drop_cnt_q <= drop_cnt_d;
      for (int i = 0; i < req_cnt; i++) begin
        grant_cnt_q[i] <= grant_cnt_d[i];
        wait_cyc_q[i]  <= wait_cyc_d[i];
      end
    end
  end

  assign grant_cnt = grant_cnt_q;
  assign wait_cyc  = wait_cyc_q;
  assign drop_cnt  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_mem_block_arbiter.sv
// Directed bench for mem_block_arbiter: a round-robin and a fixed-priority instance share
// one set of requester/memory stimulus so their grant orders can be compared side by side.
module tb_mem_block_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b1;
  sys::mem_read_block_req_t req_in [2];
  sys::mem_read_block_rsp_t mem_rsp;
  sys::mem_read_block_rsp_t rsp_rr [2];
  sys::mem_read_block_rsp_t rsp_fp [2];
  sys::mem_read_block_req_t mreq_rr, mreq_fp;
  logic       busy_rr, busy_fp;
  logic [0:0] gid_rr, gid_fp;
  logic [1:0] st_rr, st_fp;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_block_arbiter #(.req_cnt(2), .fixed_prio(1'b0)) dut_rr (
    .clk(clk), .rst(rst), .en(en), .req_in(req_in), .rsp_out(rsp_rr),
    .mem_req(mreq_rr), .mem_rsp(mem_rsp), .busy(busy_rr), .grant_id(gid_rr),
    .state_dbg(st_rr)
  );

  mem_block_arbiter #(.req_cnt(2), .fixed_prio(1'b1)) dut_fp (
    .clk(clk), .rst(rst), .en(en), .req_in(req_in), .rsp_out(rsp_fp),
    .mem_req(mreq_fp), .mem_rsp(mem_rsp), .busy(busy_fp), .grant_id(gid_fp),
    .state_dbg(st_fp)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Grant on the next edge, memory answers in the first BUSY cycle, then RETIRE and IDLE.
  task automatic txn(input logic [0:0] exp_rr, input logic [0:0] exp_fp, input logic [63:0] d);
    tick();
    chk("txn_busy_rr", 64'(busy_rr), 64'd1);
    chk("txn_gid_rr", 64'(gid_rr), 64'(exp_rr));
    chk("txn_gid_fp", 64'(gid_fp), 64'(exp_fp));
    mem_rsp = '{done: 1'b1, data: d};
    #1;
    chk("txn_done_rr", 64'(rsp_rr[exp_rr].done), 64'd1);
    chk("txn_data_rr", rsp_rr[exp_rr].data, d);
    chk("txn_other_done_rr", 64'(rsp_rr[~exp_rr].done), 64'd0);
    chk("txn_done_fp", 64'(rsp_fp[exp_fp].done), 64'd1);
    tick();
    mem_rsp = sys::mem_read_block_rsp_rst;
    chk("txn_retire_valid", 64'(mreq_rr.valid), 64'd0);
    chk("txn_retire_busy", 64'(busy_rr), 64'd1);
    tick();
    chk("txn_idle_busy", 64'(busy_rr), 64'd0);
  endtask

  initial begin
    req_in[0] = sys::mem_read_block_req_rst;
    req_in[1] = sys::mem_read_block_req_rst;
    mem_rsp   = sys::mem_read_block_rsp_rst;

    // Reset state
    #2;
    chk("rst_state", 64'(st_rr), 64'd0);
    chk("rst_busy", 64'(busy_rr), 64'd0);
    chk("rst_gid", 64'(gid_rr), 64'd0);
    chk("rst_mreq", 64'(mreq_rr), 64'd0);
    chk("rst_rsp0", 64'(rsp_rr[0]), 64'd0);
    #10 rst = 1'b1;

    // Single request on port 1, memory done three cycles after mem_req.valid
    req_in[1] = '{valid: 1'b1, addr: 32'h0000_1040};
    tick();
    chk("s_mreq_valid", 64'(mreq_rr.valid), 64'd1);
    chk("s_mreq_addr", 64'(mreq_rr.addr), 64'h1040);
    chk("s_gid", 64'(gid_rr), 64'd1);
    chk("s_state", 64'(st_rr), 64'd1);
    tick();
    req_in[1].addr = 32'hFFFF_0000;
    tick();
    chk("s_addr_latched", 64'(mreq_rr.addr), 64'h1040);
    chk("s_no_early_done", 64'(rsp_rr[1].done), 64'd0);
    tick();
    mem_rsp = '{done: 1'b1, data: 64'hCAFE_0000_1234_5678};
    #1;
    chk("s_done1", 64'(rsp_rr[1].done), 64'd1);
    chk("s_data1", rsp_rr[1].data, 64'hCAFE_0000_1234_5678);
    chk("s_done0", 64'(rsp_rr[0].done), 64'd0);
    chk("s_data0", rsp_rr[0].data, 64'd0);
    tick();
    // Stale valid and a stray done during RETIRE must not re-grant or respond.
    chk("s_retire_state", 64'(st_rr), 64'd2);
    chk("s_retire_done", 64'(rsp_rr[1].done), 64'd0);
    chk("s_retire_data", rsp_rr[1].data, 64'd0);
    chk("s_retire_busy", 64'(busy_rr), 64'd1);
    tick();
    req_in[1].valid = 1'b0;
    mem_rsp = sys::mem_read_block_rsp_rst;
    chk("s_idle_busy", 64'(busy_rr), 64'd0);
    chk("s_idle_state", 64'(st_rr), 64'd0);

    // Contention: round-robin alternates, fixed priority keeps port 0
    req_in[0] = '{valid: 1'b1, addr: 32'h0000_2000};
    req_in[1] = '{valid: 1'b1, addr: 32'h0000_3000};
    txn(1'b0, 1'b0, 64'h11);
    txn(1'b1, 1'b0, 64'h22);
    txn(1'b0, 1'b0, 64'h33);
    txn(1'b1, 1'b0, 64'h44);
    req_in[0].valid = 1'b0;
    txn(1'b1, 1'b1, 64'h55);

    // Withdraw: port 0 granted, drops valid while BUSY
    req_in[0] = '{valid: 1'b1, addr: 32'h0000_4000};
    req_in[1].valid = 1'b0;
    tick();
    chk("w_gid_rr", 64'(gid_rr), 64'd0);
    chk("w_busy", 64'(busy_rr), 64'd1);
    req_in[0].valid = 1'b0;
    tick();
    mem_rsp = '{done: 1'b1, data: 64'h66};
    #1;
    chk("w_done0_rr", 64'(rsp_rr[0].done), 64'd0);
    chk("w_done1_rr", 64'(rsp_rr[1].done), 64'd0);
    chk("w_done0_fp", 64'(rsp_fp[0].done), 64'd0);
    chk("w_data0_rr", rsp_rr[0].data, 64'd0);
    tick();
    mem_rsp = sys::mem_read_block_rsp_rst;
    chk("w_retire", 64'(st_rr), 64'd2);
    tick();
    chk("w_idle", 64'(busy_rr), 64'd0);

    // en low while BUSY: completion still delivered, no new grant until en returns
    req_in[0].valid = 1'b1;
    tick();
    chk("e_gid_rr", 64'(gid_rr), 64'd0);
    en = 1'b0;
    req_in[1].valid = 1'b1;
    tick();
    mem_rsp = '{done: 1'b1, data: 64'h77};
    #1;
    chk("e_done0", 64'(rsp_rr[0].done), 64'd1);
    chk("e_data0", rsp_rr[0].data, 64'h77);
    tick();
    mem_rsp = sys::mem_read_block_rsp_rst;
    tick();
    chk("e_idle1", 64'(busy_rr), 64'd0);
    tick();
    chk("e_idle2", 64'(busy_rr), 64'd0);
    chk("e_idle2_mreq", 64'(mreq_rr.valid), 64'd0);
    en = 1'b1;
    tick();
    chk("e_regrant_busy", 64'(busy_rr), 64'd1);
    chk("e_regrant_rr", 64'(gid_rr), 64'd1);
    chk("e_regrant_fp", 64'(gid_fp), 64'd0);

    // Reset in the middle of a transaction, late done afterwards
    #3 rst = 1'b0;
    #1;
    chk("r_mreq_valid", 64'(mreq_rr.valid), 64'd0);
    chk("r_busy", 64'(busy_rr), 64'd0);
    chk("r_gid", 64'(gid_rr), 64'd0);
    chk("r_state", 64'(st_rr), 64'd0);
    en = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    mem_rsp = '{done: 1'b1, data: 64'h88};
    #1;
    chk("r_late_done0", 64'(rsp_rr[0].done), 64'd0);
    chk("r_late_done1", 64'(rsp_rr[1].done), 64'd0);
    tick();
    chk("r_after_busy", 64'(busy_rr), 64'd0);
    chk("r_after_gid", 64'(gid_rr), 64'd0);
    chk("r_after_done1", 64'(rsp_rr[1].done), 64'd0);
    mem_rsp = sys::mem_read_block_rsp_rst;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
